vga_video_out: RTL and testbench

Downstream stage of the VGA timing counter. Consumes the free-running `hpos`/`vpos` raster position on the pixel clock and produces registered `hsync`, `vsync` and `blank`, plus a selectable test-pattern colour per pixel. It is the last stage before the DAC/pins. All outputs are mutually aligned behind a fixed 2-cycle pipeline.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_pattern_gen.sv | 50 +++++
 rtl/vga_video_out.sv | 168 ++++++++++++++++
 tb/tb_vga_video_out.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, pattern mode encoding and colour width
package vga_pkg;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_TOTAL_DEF   = 800;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_TOTAL_DEF   = 525;
   localparam int BAR_W_DEF     = 80;

   localparam int CW = 4;

   typedef enum logic [1:0] {
      MODE_BARS     = 2'd0,
      MODE_CHECKER  = 2'd1,
      MODE_GRADIENT = 2'd2,
      MODE_WHITE    = 2'd3
   } mode_e;

endpackage

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - combinational test-pattern colour for one pixel
module vga_pattern_gen
   import vga_pkg::*;
(
   input  logic [7:0]    x,
   input  logic [3:0]    y_hi,
   input  logic [2:0]    bar,
   input  logic [7:0]    frame,
   input  mode_e         mode,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue
);

   // Only bit 5 of the scrolled x matters; a 6-bit sum is enough
   logic [5:0] xs;

   // Select the colour of the latched pattern; y_hi[1] is y[5]
   always_comb begin
      xs    = x[5:0] + frame[5:0];
      red   = '0;
      green = '0;
      blue  = '0;
      case (mode)
         MODE_BARS: begin
            red   = {CW{~bar[1]}};
            green = {CW{~bar[2]}};
            blue  = {CW{~bar[0]}};
         end
         MODE_CHECKER: begin
            if ((xs >= 6'd32) ^ y_hi[1]) begin
               red   = '1;
               green = '1;
               blue  = '1;
            end
         end
         MODE_GRADIENT: begin
            red   = x[7:4];
            green = y_hi;
            blue  = frame[7:4];
         end
         default: begin
            red   = '1;
            green = '1;
            blue  = '1;
         end
      endcase
   end

endmodule

// File: rtl/vga_video_out.sv
// rtl/vga_video_out.sv - two-stage sync/blank/test-pattern output stage of the VGA pipe
module vga_video_out
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE   = H_VISIBLE_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_TOTAL     = H_TOTAL_DEF,
   parameter int   V_VISIBLE   = V_VISIBLE_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_TOTAL     = V_TOTAL_DEF,
   parameter logic SYNC_ACTIVE = 1'b0,
   parameter int   BAR_W       = BAR_W_DEF
) (
   input  logic          px_clk,
   input  logic          rst,
   input  logic [13:0]   hpos,
   input  logic [13:0]   vpos,
   input  logic [1:0]    mode,
   output logic          hsync,
   output logic          vsync,
   output logic          blank,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue,
   output logic          frame_start,
   output logic [7:0]    frame_count
);

   localparam logic [13:0] H_VIS    = 14'(H_VISIBLE);
   localparam logic [13:0] HS_START = 14'(H_VISIBLE + H_FRONT);
   localparam logic [13:0] HS_END   = 14'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [13:0] H_TOT    = 14'(H_TOTAL);
   localparam logic [13:0] V_VIS    = 14'(V_VISIBLE);
   localparam logic [13:0] VS_START = 14'(V_VISIBLE + V_FRONT);
   localparam logic [13:0] VS_END   = 14'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [13:0] V_TOT    = 14'(V_TOTAL);
   localparam int          SW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);

   // Stage 1 registers
   logic          vis1_q, vis1_d;
   logic          hs1_q, hs1_d;
   logic          vs1_q, vs1_d;
   logic          fs1_q, fs1_d;
   logic [7:0]    x1_q, x1_d;
   logic [3:0]    y1_q, y1_d;
   logic [SW-1:0] sub_q, sub_d;
   logic [2:0]    bar_q, bar_d;
   mode_e         mode_q, mode_d;

   // Stage 2 (output) registers
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          blank_q, blank_d;
   logic [CW-1:0] red_q, red_d;
   logic [CW-1:0] green_q, green_d;
   logic [CW-1:0] blue_q, blue_d;
   logic          frame_start_q, frame_start_d;
   logic [7:0]    frame_count_q, frame_count_d;

   logic [CW-1:0] pg_red, pg_green, pg_blue;

   // Stage 1: decode raster position, step bar counters, latch mode at (0,0)
   always_comb begin
      vis1_d = (hpos < H_VIS) && (vpos < V_VIS);
      hs1_d  = (hpos < H_TOT) && (hpos >= HS_START) && (hpos < HS_END);
      vs1_d  = (vpos < V_TOT) && (vpos >= VS_START) && (vpos < VS_END);
      fs1_d  = (hpos == '0) && (vpos == '0);
      x1_d   = hpos[7:0];
      y1_d   = vpos[7:4];
      mode_d = fs1_d ? mode_e'(mode) : mode_q;
      sub_d  = sub_q;
      bar_d  = bar_q;
      if (hpos == '0) begin
         sub_d = '0;
         bar_d = '0;
      end else if (sub_q == SUB_LAST) begin
         sub_d = '0;
         bar_d = bar_q + 3'd1;
      end else begin
         sub_d = sub_q + SW'(1);
      end
   end

   // Stage 1 flops; reset leaves the pipe in the blank / no-sync state
   always_ff @(posedge px_clk or posedge rst) begin
      if (rst) begin
         vis1_q <= 1'b0;
         hs1_q  <= 1'b0;
         vs1_q  <= 1'b0;
         fs1_q  <= 1'b0;
         x1_q   <= '0;
         y1_q   <= '0;
         sub_q  <= '0;
         bar_q  <= '0;
         mode_q <= MODE_BARS;
      end else begin
         vis1_q <= vis1_d;
         hs1_q  <= hs1_d;
         vs1_q  <= vs1_d;
         fs1_q  <= fs1_d;
         x1_q   <= x1_d;
         y1_q   <= y1_d;
         sub_q  <= sub_d;
         bar_q  <= bar_d;
         mode_q <= mode_d;
      end
   end

   // The colour of pixel (0,0) must already see the new frame index
   vga_pattern_gen u_pattern (
      .x     (x1_q),
      .y_hi  (y1_q),
      .bar   (bar_q),
      .frame (frame_count_d),
      .mode  (mode_q),
      .red   (pg_red),
      .green (pg_green),
      .blue  (pg_blue)
   );

   // Stage 2: sync polarity, blanking of colour, frame counter
   always_comb begin
      frame_count_d = fs1_q ? frame_count_q + 8'd1 : frame_count_q;
      frame_start_d = fs1_q;
      hsync_d       = hs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = vs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      blank_d       = ~vis1_q;
      red_d         = vis1_q ? pg_red   : '0;
      green_d       = vis1_q ? pg_green : '0;
      blue_d        = vis1_q ? pg_blue  : '0;
   end

   // Stage 2 flops drive the pins directly
   always_ff @(posedge px_clk or posedge rst) begin
      if (rst) begin
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         blank_q       <= 1'b1;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_q       <= blank_d;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_video_out.sv
// tb/tb_vga_video_out.sv - scoreboard bench for vga_video_out
module tb_vga_video_out;

   logic        px_clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] hpos = 14'd100;
   logic [13:0] vpos = 14'd300;
   logic [1:0]  mode = 2'd0;
   logic        hsync, vsync, blank, frame_start;
   logic [3:0]  red, green, blue;
   logic [7:0]  frame_count;

   vga_video_out dut (
      .px_clk      (px_clk),
      .rst         (rst),
      .hpos        (hpos),
      .vpos        (vpos),
      .mode        (mode),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   always #5 px_clk = ~px_clk;

   typedef struct {
      int          due;
      int          tag;
      int          h;
      int          v;
      bit          chk_rgb;
      logic        hs;
      logic        vs;
      logic        bl;
      logic        fs;
      logic [7:0]  fc;
      logic [11:0] rgb;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   cur_tag = 0;
   int   bl_low[8];
   int   hs_low[8];
   int   vs_low[8];
   int   fs_cnt[8];
   int   m_f = 0;
   int   m_mode = 0;
   logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

   always @(posedge px_clk) cyc++;

   // Monitor: compare every output whose sample is due this cycle
   initial begin
      exp_t        e;
      logic [23:0] act, req, mask;
      for (int i = 0; i < 8; i++) begin
         bl_low[i] = 0; hs_low[i] = 0; vs_low[i] = 0; fs_cnt[i] = 0;
      end
      forever begin
         @(posedge px_clk);
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            e    = q.pop_front();
            act  = {hsync, vsync, blank, frame_start, frame_count, red, green, blue};
            req  = {e.hs, e.vs, e.bl, e.fs, e.fc, e.rgb};
            mask = e.chk_rgb ? 24'hFFFFFF : 24'hFFF000;
            checks++;
            if ((act & mask) !== (req & mask)) begin
               failures++;
               $display("FAIL px tag=%0d h=%0d v=%0d actual=%h required=%h mask=%h",
                        e.tag, e.h, e.v, act, req, mask);
            end
            if (!blank) bl_low[e.tag]++;
            if (!hsync) hs_low[e.tag]++;
            if (!vsync) vs_low[e.tag]++;
            if (frame_start) fs_cnt[e.tag]++;
         end
      end
   end

   // Drive one raster position and queue what the pins must show 2 edges later
   task automatic drive_px(input int h, input int v, input logic [1:0] m,
                           input bit seq, input bit hand, input logic [11:0] hand_rgb);
      exp_t e;
      bit   vis;
      @(negedge px_clk);
      hpos = 14'(h);
      vpos = 14'(v);
      mode = m;
      if (h == 0 && v == 0) begin
         m_f    = (m_f + 1) % 256;
         m_mode = int'(m);
      end
      vis       = (h < 640) && (v < 480);
      e.due     = cyc + 2;
      e.tag     = cur_tag;
      e.h       = h;
      e.v       = v;
      e.hs      = !(h >= 656 && h < 752);
      e.vs      = !(v >= 490 && v < 492);
      e.bl      = !vis;
      e.fs      = (h == 0 && v == 0);
      e.fc      = 8'(m_f);
      e.chk_rgb = 1'b1;
      if (!vis) e.rgb = 12'h000;
      else if (hand) e.rgb = hand_rgb;
      else begin
         case (m_mode)
            0: begin e.rgb = bar_tab[h / 80]; e.chk_rgb = seq; end
            1: e.rgb = ((((h + m_f) >> 5) & 1) ^ ((v >> 5) & 1)) != 0 ? 12'hFFF : 12'h000;
            2: e.rgb = {4'(h >> 4), 4'(v >> 4), 4'(m_f >> 4)};
            default: e.rgb = 12'hFFF;
         endcase
      end
      q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge px_clk);
         n++;
      end
      @(posedge px_clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual_pending=%0d required=0", q.size());
         q.delete();
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic check_reset(input string name);
      logic [23:0] act;
      act = {hsync, vsync, blank, frame_start, frame_count, red, green, blue};
      checks++;
      if (act !== 24'hE00000) begin
         failures++;
         $display("FAIL %s actual=%h required=e00000", name, act);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      repeat (3) @(posedge px_clk);
      #1 check_reset("reset_por");
      @(negedge px_clk);
      rst = 1'b0;

      // Reset asserted mid-line while in sync, then released
      cur_tag = 1;
      drive_px(0, 0, 2'd0, 1'b0, 1'b0, 12'h000);
      drive_px(700, 490, 2'd0, 1'b0, 1'b0, 12'h000);
      drain();
      @(negedge px_clk);
      #2 rst = 1'b1;
      #1 check_reset("reset_async");
      m_f = 0;
      m_mode = 0;
      @(negedge px_clk);
      rst = 1'b0;
      @(posedge px_clk);
      #1 check_reset("reset_hold1");

      // One full line at vpos 100: horizontal timing and colour bars
      cur_tag = 2;
      for (int h = 0; h < 800; h++) begin
         case (h)
            0:       drive_px(h, 100, 2'd0, 1'b1, 1'b1, 12'hFFF);
            80:      drive_px(h, 100, 2'd0, 1'b1, 1'b1, 12'hFF0);
            560:     drive_px(h, 100, 2'd0, 1'b1, 1'b1, 12'h000);
            700:     drive_px(h, 100, 2'd0, 1'b1, 1'b1, 12'h000);
            default: drive_px(h, 100, 2'd0, 1'b1, 1'b0, 12'h000);
         endcase
      end
      drain();
      check_int("line_blank_low", bl_low[2], 640);
      check_int("line_hsync_low", hs_low[2], 96);
      check_int("line_vsync_low", vs_low[2], 0);

      // Whole frame: full lines around the vertical transitions, sparse elsewhere
      cur_tag = 3;
      for (int v = 0; v < 525; v++) begin
         if (v >= 478 && v <= 493) begin
            for (int h = 0; h < 800; h++) drive_px(h, v, 2'd0, 1'b1, 1'b0, 12'h000);
         end else begin
            drive_px(0, v, 2'd0, 1'b0, 1'b0, 12'h000);
            drive_px(639, v, 2'd0, 1'b0, 1'b0, 12'h000);
            drive_px(640, v, 2'd0, 1'b0, 1'b0, 12'h000);
            drive_px(700, v, 2'd0, 1'b0, 1'b0, 12'h000);
         end
      end
      drain();
      check_int("frame_vsync_low", vs_low[3], 1600);
      check_int("frame_hsync_low", hs_low[3], 16 * 96 + 509);
      check_int("frame_start_cnt", fs_cnt[3], 1);

      // Many short frames in checker mode: frame counter wrap and scrolling
      cur_tag = 6;
      for (int f = 0; f < 300; f++) begin
         drive_px(0, 0, 2'd1, 1'b0, 1'b0, 12'h000);
         drive_px(31, 0, 2'd1, 1'b0, 1'b0, 12'h000);
         drive_px(32, 5, 2'd1, 1'b0, 1'b0, 12'h000);
         drive_px(40, 40, 2'd1, 1'b0, 1'b0, 12'h000);
         drive_px(700, 0, 2'd1, 1'b0, 1'b0, 12'h000);
      end
      drain();
      check_int("frames_start_cnt", fs_cnt[6], 300);
      check_int("frames_count_final", int'(frame_count), 45);

      // Mode change mid-frame only applies from the next frame
      cur_tag = 5;
      drive_px(0, 0, 2'd0, 1'b0, 1'b0, 12'h000);
      for (int h = 0; h < 800; h++) begin
         case (h)
            40:      drive_px(h, 200, 2'd2, 1'b1, 1'b1, 12'hFFF);
            120:     drive_px(h, 200, 2'd2, 1'b1, 1'b1, 12'hFF0);
            default: drive_px(h, 200, 2'd2, 1'b1, 1'b0, 12'h000);
         endcase
      end
      drive_px(0, 0, 2'd2, 1'b0, 1'b0, 12'h000);
      drive_px(8'h50, 8'h30, 2'd2, 1'b0, 1'b1, 12'h532);
      drive_px(8'hF0, 8'h70, 2'd2, 1'b0, 1'b1, 12'hF72);
      drive_px(900, 100, 2'd2, 1'b0, 1'b0, 12'h000);
      drive_px(100, 600, 2'd2, 1'b0, 1'b0, 12'h000);
      drain();
      check_int("mode_frame_starts", fs_cnt[5], 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
